// File: rtl/slimit_pkg.sv
// Shared types and the wide signed compare/select used by both limiter stages.
// Values are carried at 33 bits so any WIDTH up to 32 clamps exactly, including -2^(WIDTH-1).
package slimit_pkg;

  localparam int CW = 33;

  typedef logic signed [CW-1:0] cval_t;

  typedef struct packed {
    logic clip;
    logic slew;
  } lim_flags_t;

  // max(lo, min(a, hi)): lo wins when the window is inverted
  function automatic cval_t sclamp3(input cval_t a, input cval_t lo, input cval_t hi);
    cval_t t;
    t = (a > hi) ? hi : a;
    return (t < lo) ? lo : t;
  endfunction

endpackage

// File: rtl/slimit_clamp_stage.sv
// First pipeline stage of slimit_slew: clamps the incoming sample to [lo,hi] and
// registers it with its channel and clip flag whenever the stage is allowed to advance.
module slimit_clamp_stage
  import slimit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CH_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_en,
  input  logic                    i_valid,
  input  logic [CH_W-1:0]         i_ch,
  input  logic signed [WIDTH-1:0] i_data,
  input  logic signed [WIDTH-1:0] i_lo,
  input  logic signed [WIDTH-1:0] i_hi,
  output logic                    o_valid,
  output logic [CH_W-1:0]         o_ch,
  output logic signed [WIDTH-1:0] o_data,
  output logic                    o_clip
);

  cval_t w_a;
  cval_t w_c;

  assign w_a = cval_t'(i_data);
  assign w_c = sclamp3(w_a, cval_t'(i_lo), cval_t'(i_hi));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_ch    <= '0;
      o_data  <= '0;
      o_clip  <= 1'b0;
    end else if (i_en) begin
      o_valid <= i_valid;
      o_ch    <= i_ch;
      o_data  <= WIDTH'(w_c);
      o_clip  <= (w_c != w_a);
    end
  end

endmodule

// File: rtl/slimit_slew.sv
// Multi-channel signed limiter: window clamp (stage 1) followed by a per-channel
// slew-rate limit against that channel's previous output (stage 2, the output register).
module slimit_slew
  import slimit_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int CH_W     = ($clog2(CHANNELS) > 0) ? $clog2(CHANNELS) : 1,
  parameter int SLEW_EN  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CH_W-1:0]         in_ch,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic signed [WIDTH-1:0] lo_limit,
  input  logic signed [WIDTH-1:0] hi_limit,
  input  logic [WIDTH-2:0]        rate,
  input  logic                    init,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CH_W-1:0]         out_ch,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    out_clip,
  output logic                    out_slew,
  output logic [CHANNELS-1:0]     sticky_clip,
  input  logic                    sticky_clr
);

  logic                    w_adv1;
  logic                    w_adv2;
  logic                    w_load;
  logic                    w_s1_valid;
  logic [CH_W-1:0]         w_s1_ch;
  logic signed [WIDTH-1:0] w_s1_data;
  logic                    w_s1_clip;
  logic signed [WIDTH-1:0] w_hist;
  logic signed [WIDTH-1:0] w_y;
  cval_t                   w_d;
  cval_t                   w_dl;
  cval_t                   w_rate;
  lim_flags_t              w_flags;
  logic [CHANNELS-1:0]     w_set;
  logic signed [WIDTH-1:0] r_hist [CHANNELS];

  assign w_adv2   = !out_valid || out_ready;
  assign w_adv1   = !w_s1_valid || w_adv2;
  assign w_load   = w_adv2 && w_s1_valid;
  assign in_ready = w_adv1;

  slimit_clamp_stage #(
    .WIDTH (WIDTH),
    .CH_W  (CH_W)
  ) u_clamp (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_adv1),
    .i_valid (in_valid),
    .i_ch    (in_ch),
    .i_data  (in_data),
    .i_lo    (lo_limit),
    .i_hi    (hi_limit),
    .o_valid (w_s1_valid),
    .o_ch    (w_s1_ch),
    .o_data  (w_s1_data),
    .o_clip  (w_s1_clip)
  );

  // History of the channel currently in stage 1 and the sticky-set mask for it
  always_comb begin
    w_hist = '0;
    w_set  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_hist   = (w_s1_ch == CH_W'(k)) ? r_hist[k] : w_hist;
      w_set[k] = w_load && w_s1_clip && (w_s1_ch == CH_W'(k));
    end
  end

  // y stays between hist and c, so the truncation back to WIDTH is lossless
  always_comb begin
    w_d          = cval_t'(w_s1_data) - cval_t'(w_hist);
    w_rate       = cval_t'(rate);
    w_dl         = sclamp3(w_d, -w_rate, w_rate);
    w_flags.clip = w_s1_clip;
    if (SLEW_EN != 0) begin
      w_y          = WIDTH'(cval_t'(w_hist) + w_dl);
      w_flags.slew = (w_dl != w_d);
    end else begin
      w_y          = w_s1_data;
      w_flags.slew = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      out_clip  <= 1'b0;
      out_slew  <= 1'b0;
    end else if (w_adv2) begin
      out_valid <= w_s1_valid;
      if (w_s1_valid) begin
        out_ch   <= w_s1_ch;
        out_data <= w_y;
        out_clip <= w_flags.clip;
        out_slew <= w_flags.slew;
      end
    end
  end

  // A stage-2 load beats init for its own channel; init zeroes the rest
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CHANNELS; k++) r_hist[k] <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (w_load && (w_s1_ch == CH_W'(k))) r_hist[k] <= w_y;
        else if (init)                       r_hist[k] <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_clip <= '0;
    else        sticky_clip <= w_set | (sticky_clr ? {CHANNELS{1'b0}} : sticky_clip);
  end

endmodule

// File: tb/tb_slimit_slew.sv
// Directed self-checking bench for slimit_slew (WIDTH=16, CHANNELS=4, SLEW_EN=1).
module tb_slimit_slew;

  localparam int WIDTH    = 16;
  localparam int CHANNELS = 4;
  localparam int CH_W     = 2;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    in_valid, in_ready, init, out_valid, out_ready;
  logic                    out_clip, out_slew, sticky_clr;
  logic [CH_W-1:0]         in_ch, out_ch;
  logic signed [WIDTH-1:0] in_data, lo_limit, hi_limit, out_data;
  logic [WIDTH-2:0]        rate;
  logic [CHANNELS-1:0]     sticky_clip;

  int n_chk  = 0;
  int n_fail = 0;
  int got_q[$];
  int blk_at;

  always #5 clk = ~clk;

  slimit_slew #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS),
    .SLEW_EN  (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ch       (in_ch),
    .in_data     (in_data),
    .lo_limit    (lo_limit),
    .hi_limit    (hi_limit),
    .rate        (rate),
    .init        (init),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ch      (out_ch),
    .out_data    (out_data),
    .out_clip    (out_clip),
    .out_slew    (out_slew),
    .sticky_clip (sticky_clip),
    .sticky_clr  (sticky_clr)
  );

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One isolated sample: idle at +1 clk, valid with result at +2 clk; side = {init, sticky_clr} at the S2 load
  task automatic do_one(input int ch, input int data, input int exp_d, input int exp_clip,
                        input int exp_slew, input logic [1:0] side, input string tag);
    @(negedge clk);
    in_valid = 1'b1;
    in_ch    = CH_W'(ch);
    in_data  = WIDTH'(data);
    #1;
    chk({tag, "_rdy"}, in_ready, 1);
    @(negedge clk);
    in_valid   = 1'b0;
    sticky_clr = side[0];
    init       = side[1];
    chk({tag, "_lat1"}, out_valid, 0);
    @(negedge clk);
    sticky_clr = 1'b0;
    init       = 1'b0;
    chk({tag, "_lat2"}, out_valid, 1);
    chk({tag, "_data"}, out_data, exp_d);
    chk({tag, "_ch"}, out_ch, ch);
    chk({tag, "_clip"}, out_clip, exp_clip);
    chk({tag, "_slew"}, out_slew, exp_slew);
  endtask

  // Streams n samples base+step*i on one channel, with out_ready low for the first 'stall' cycles
  task automatic stream(input int ch, input int base, input int step, input int n, input int stall);
    int n_acc;
    logic held_pend;
    logic signed [WIDTH-1:0] held_val;
    got_q.delete();
    blk_at    = -1;
    n_acc     = 0;
    held_pend = 1'b0;
    held_val  = '0;
    for (int cyc = 0; cyc < n + stall + 8; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= stall);
      in_valid  = (n_acc < n);
      in_ch     = CH_W'(ch);
      in_data   = WIDTH'(base + step * n_acc);
      #1;
      if (in_valid && !in_ready && blk_at < 0) blk_at = n_acc;
      if (held_pend) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, held_val);
      end
      held_pend = out_valid && !out_ready;
      held_val  = out_data;
      if (out_valid && out_ready) got_q.push_back(int'(out_data));
      if (in_valid && in_ready) n_acc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    in_valid   = 1'b0;
    in_ch      = '0;
    in_data    = '0;
    lo_limit   = -16'sd100;
    hi_limit   = 16'sd200;
    rate       = 15'h7FFF;
    init       = 1'b0;
    out_ready  = 1'b1;
    sticky_clr = 1'b0;

    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_out_clip", out_clip, 0);
    chk("rst_out_slew", out_slew, 0);
    chk("rst_sticky", sticky_clip, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Window clamp
    do_one(0, 150, 150, 0, 0, 2'b00, "t1a");
    do_one(0, 250, 200, 1, 0, 2'b00, "t1b");
    do_one(0, -32768, -100, 1, 0, 2'b00, "t1c");
    chk("t1_sticky", sticky_clip, 4'b0001);

    // Slew from zero history
    do_reset();
    lo_limit = -16'sd32768;
    hi_limit = 16'sd32767;
    rate     = 15'd10;
    do_one(1, 50, 10, 0, 1, 2'b00, "t2a");
    do_one(1, 50, 20, 0, 1, 2'b00, "t2b");
    do_one(1, 5, 10, 0, 1, 2'b00, "t2c");

    // Interleaved channels keep independent histories
    do_reset();
    do_one(0, 100, 10, 0, 1, 2'b00, "t3a");
    do_one(1, 100, 10, 0, 1, 2'b00, "t3b");
    do_one(0, 100, 20, 0, 1, 2'b00, "t3c");

    // Back-to-back samples on one channel see the freshly written history
    stream(3, 100, 0, 3, 0);
    chk("t3s_noblock", blk_at, -1);
    chk("t3s_count", got_q.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < got_q.size()) chk("t3s_data", got_q[i], 10 * (i + 1));

    // Backpressure
    rate = 15'h7FFF;
    stream(2, 1, 1, 4, 5);
    chk("t4_block_after", blk_at, 2);
    chk("t4_count", got_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < got_q.size()) chk("t4_order", got_q[i], i + 1);

    // Inverted window and sticky clip
    do_reset();
    lo_limit = 16'sd300;
    hi_limit = 16'sd200;
    do_one(2, 250, 300, 1, 0, 2'b00, "t5a");
    chk("t5_sticky_set", sticky_clip, 4'b0100);
    @(negedge clk);
    sticky_clr = 1'b1;
    @(negedge clk);
    sticky_clr = 1'b0;
    chk("t5_sticky_clr", sticky_clip, 0);
    do_one(2, 250, 300, 1, 0, 2'b01, "t5b");
    chk("t5_set_wins", sticky_clip, 4'b0100);

    // init coinciding with a ch2 load, then mid-stream reset
    do_reset();
    lo_limit = -16'sd32768;
    hi_limit = 16'sd32767;
    rate     = 15'd10;
    do_one(0, 100, 10, 0, 1, 2'b00, "t6a");
    do_one(1, 100, 10, 0, 1, 2'b00, "t6b");
    do_one(2, 100, 10, 0, 1, 2'b00, "t6c");
    do_one(2, 100, 20, 0, 1, 2'b10, "t6_init");
    do_one(0, 100, 10, 0, 1, 2'b00, "t6_h0");
    do_one(1, 100, 10, 0, 1, 2'b00, "t6_h1");
    do_one(2, 100, 30, 0, 1, 2'b00, "t6_h2");
    chk("t6_sticky", sticky_clip, 0);

    @(negedge clk);
    in_valid = 1'b1;
    in_ch    = 2'd0;
    in_data  = 16'sd100;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t6_pre_valid", out_valid, 1);
    chk("t6_pre_data", out_data, 20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_one(0, 100, 10, 0, 1, 2'b00, "t6_post");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
